// File: rtl/sigmoid_backward_pkg.sv
// Shared Q0.7 activation constants and helpers for the sigmoid backward pipeline.
package sigmoid_backward_pkg;

  localparam int unsigned ACT_FRAC    = 7;
  localparam logic [ACT_FRAC-1:0] ACT_ONE = 7'd127;
  localparam int unsigned DERIV_SHIFT = 14;
  localparam int unsigned DERIV_W     = 13;

  // Forward outputs above 1.0 in Q0.7 saturate at ACT_ONE.
  function automatic logic [ACT_FRAC-1:0] act_clamp(input logic [7:0] y);
    return (y > 8'(ACT_ONE)) ? ACT_ONE : y[ACT_FRAC-1:0];
  endfunction

endpackage

// File: rtl/sigmoid_backward_if.sv
// Valid/ready input and output streams of the sigmoid backward pipeline.
interface sigmoid_backward_if #(parameter int GRAD_W = 16);

  logic                     in_valid;
  logic                     in_ready;
  logic [7:0]               y_in;
  logic signed [GRAD_W-1:0] grad_in;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [GRAD_W-1:0] grad_out;

  modport master (
    output in_valid, y_in, grad_in, out_ready,
    input  in_ready, out_valid, grad_out
  );

  modport slave (
    input  in_valid, y_in, grad_in, out_ready,
    output in_ready, out_valid, grad_out
  );

endinterface

// File: rtl/sigmoid_deriv_mul.sv
// Combinational sigmoid derivative magnitude y*(1-y) in Q0.7 x Q0.7 = Q0.14.
module sigmoid_deriv_mul
  import sigmoid_backward_pkg::*;
(
  input  logic [ACT_FRAC-1:0] y_i,
  input  logic [ACT_FRAC-1:0] c_i,
  output logic [DERIV_W-1:0]  d_o
);

  // y + c == 127, so the product peaks at 63*64 = 4032 and fits in DERIV_W bits.
  assign d_o = DERIV_W'(y_i) * DERIV_W'(c_i);

endmodule

// File: rtl/sigmoid_backward.sv
// Three-stage sigmoid backward pass: grad_out = grad_in * y * (1 - y).
// Define SIGMOID_BWD_ROUND_EN to round half up in stage 3 instead of truncating.
module sigmoid_backward
  import sigmoid_backward_pkg::*;
#(
  parameter int GRAD_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  sigmoid_backward_if.slave  bus
);

  localparam int PW = GRAD_W + DERIV_W + 1;

`ifdef SIGMOID_BWD_ROUND_EN
  localparam logic signed [PW-1:0] P_BIAS = PW'(1 << (DERIV_SHIFT - 1));
`else
  localparam logic signed [PW-1:0] P_BIAS = '0;
`endif

  logic                     v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [ACT_FRAC-1:0]      y1_q, y1_d, c1_q, c1_d;
  logic signed [GRAD_W-1:0] g1_q, g1_d, g2_q, g2_d;
  logic [DERIV_W-1:0]       d2_q, d2_d;
  logic signed [GRAD_W-1:0] gout_q, gout_d;

  logic                     advance;
  logic [ACT_FRAC-1:0]      y_cl;
  logic [DERIV_W-1:0]       d_mul;
  logic signed [PW-1:0]     g_ext, d_ext, prod, p_adj;
  logic signed [GRAD_W-1:0] p_res;

  assign advance       = !v3_q || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = v3_q;
  assign bus.grad_out  = gout_q;

  assign y_cl = act_clamp(bus.y_in);

  sigmoid_deriv_mul u_deriv_mul (
    .y_i (y1_q),
    .c_i (c1_q),
    .d_o (d_mul)
  );

  // d is unsigned, so it is zero-extended before the signed multiply.
  assign g_ext = PW'(g2_q);
  assign d_ext = $signed(PW'(d2_q));
  assign prod  = g_ext * d_ext;
  assign p_adj = prod + P_BIAS;
  assign p_res = GRAD_W'(p_adj >>> DERIV_SHIFT);

  always_comb begin
    v1_d   = v1_q;
    v2_d   = v2_q;
    v3_d   = v3_q;
    y1_d   = y1_q;
    c1_d   = c1_q;
    g1_d   = g1_q;
    d2_d   = d2_q;
    g2_d   = g2_q;
    gout_d = gout_q;
    if (advance) begin
      v1_d   = bus.in_valid;
      y1_d   = y_cl;
      c1_d   = ACT_ONE - y_cl;
      g1_d   = bus.grad_in;
      v2_d   = v1_q;
      d2_d   = d_mul;
      g2_d   = g1_q;
      v3_d   = v2_q;
      gout_d = p_res;
    end
    // Flush wins over any transfer in the same cycle.
    if (flush) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
      v3_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      y1_q   <= '0;
      c1_q   <= '0;
      g1_q   <= '0;
      d2_q   <= '0;
      g2_q   <= '0;
      gout_q <= '0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      y1_q   <= y1_d;
      c1_q   <= c1_d;
      g1_q   <= g1_d;
      d2_q   <= d2_d;
      g2_q   <= g2_d;
      gout_q <= gout_d;
    end
  end

endmodule
